// File: rtl/fpu_adder_if.sv
// Operand/result bundle for fpu_adder, plus the FSM state for observation.
// There is no valid/ready: operands are sampled whenever dbg_state is LOAD, and
// data_out/status_out change only on the clock edge that leaves OUT.
interface fpu_adder_if;
   logic [31:0] op_A_in;
   logic [31:0] op_B_in;
   logic [31:0] data_out;
   logic [3:0]  status_out;
   logic [2:0]  dbg_state;

   modport master (output op_A_in, op_B_in, input data_out, status_out, dbg_state);
   modport slave  (input op_A_in, op_B_in, output data_out, status_out, dbg_state);
endinterface

// File: rtl/fpu_adder.sv
// Multi-cycle adder for a 1/6/25 float format (bias 31, no denormals/Inf/NaN).
// Round-toward-zero; each pass is LOAD -> ALIGN -> ADD -> NORM -> OUT.
module fpu_adder (
   input  logic       clock100KHz,
   input  logic       reset,
   fpu_adder_if.slave bus
);
   typedef enum logic [2:0] {
      ST_LOAD  = 3'd0,
      ST_ALIGN = 3'd1,
      ST_ADD   = 3'd2,
      ST_NORM  = 3'd3,
      ST_OUT   = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic               sign_a_q, sign_a_d;
   logic               sign_b_q, sign_b_d;
   logic [5:0]         exp_b_q, exp_b_d;
   logic signed [7:0]  exp_r_q, exp_r_d;
   logic [28:0]        man_a_q, man_a_d;
   logic [28:0]        man_b_q, man_b_d;
   logic [29:0]        sum_q, sum_d;
   logic [31:0]        data_q, data_d;
   logic [3:0]         status_q, status_d;

   logic [5:0]  in_exp_a, in_exp_b, exp_diff;
   logic [25:0] in_man_a, in_man_b;
   logic        a_bigger;

   // Exponent 0 encodes zero, so the hidden bit (and fraction) is suppressed.
   always_comb begin
      in_exp_a = bus.op_A_in[30:25];
      in_exp_b = bus.op_B_in[30:25];
      in_man_a = (in_exp_a == 6'd0) ? 26'd0 : {1'b1, bus.op_A_in[24:0]};
      in_man_b = (in_exp_b == 6'd0) ? 26'd0 : {1'b1, bus.op_B_in[24:0]};
      a_bigger = {in_exp_a, in_man_a} >= {in_exp_b, in_man_b};
      exp_diff = exp_r_q[5:0] - exp_b_q;
   end

   always_comb begin
      state_d  = state_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      exp_b_d  = exp_b_q;
      exp_r_d  = exp_r_q;
      man_a_d  = man_a_q;
      man_b_d  = man_b_q;
      sum_d    = sum_q;
      data_d   = data_q;
      status_d = status_q;
      case (state_q)
         ST_LOAD: begin
            if (a_bigger) begin
               sign_a_d = bus.op_A_in[31];
               sign_b_d = bus.op_B_in[31];
               exp_r_d  = {2'b00, in_exp_a};
               exp_b_d  = in_exp_b;
               man_a_d  = {in_man_a, 3'b000};
               man_b_d  = {in_man_b, 3'b000};
            end else begin
               sign_a_d = bus.op_B_in[31];
               sign_b_d = bus.op_A_in[31];
               exp_r_d  = {2'b00, in_exp_b};
               exp_b_d  = in_exp_a;
               man_a_d  = {in_man_b, 3'b000};
               man_b_d  = {in_man_a, 3'b000};
            end
            state_d = ST_ALIGN;
         end
         ST_ALIGN: begin
            if (exp_diff == 6'd0) begin
               state_d = ST_ADD;
            end else if (exp_diff > 6'd27) begin
               // B lies entirely below the sticky position: collapse in one step.
               man_b_d = {28'd0, |man_b_q};
               exp_b_d = exp_r_q[5:0];
            end else begin
               man_b_d = {1'b0, man_b_q[28:2], man_b_q[1] | man_b_q[0]};
               exp_b_d = exp_b_q + 6'd1;
            end
         end
         ST_ADD: begin
            if (sign_a_q == sign_b_q)
               sum_d = {1'b0, man_a_q} + {1'b0, man_b_q};
            else
               sum_d = {1'b0, man_a_q} - {1'b0, man_b_q};
            state_d = ST_NORM;
         end
         ST_NORM: begin
            if (sum_q[29]) begin
               sum_d   = {1'b0, sum_q[29:2], sum_q[1] | sum_q[0]};
               exp_r_d = exp_r_q + 8'sd1;
               state_d = ST_OUT;
            end else if (sum_q == 30'd0 || sum_q[28]) begin
               state_d = ST_OUT;
            end else begin
               sum_d   = {sum_q[28:0], 1'b0};
               exp_r_d = exp_r_q - 8'sd1;
            end
         end
         ST_OUT: begin
            // Truncation: guard/round/sticky only decide EXACT vs INEXACT.
            if (sum_q == 30'd0) begin
               data_d   = 32'd0;
               status_d = 4'b1000;
            end else if (exp_r_q > 8'sd63) begin
               data_d   = {sign_a_q, 6'd63, 25'h1FFFFFF};
               status_d = 4'b0100;
            end else if (exp_r_q < 8'sd1) begin
               data_d   = 32'd0;
               status_d = 4'b0010;
            end else begin
               data_d   = {sign_a_q, exp_r_q[5:0], sum_q[27:3]};
               status_d = (sum_q[2:0] != 3'd0) ? 4'b0001 : 4'b1000;
            end
            state_d = ST_LOAD;
         end
         default: state_d = ST_LOAD;
      endcase
   end

   always_ff @(posedge clock100KHz) begin
      if (reset) begin
         state_q  <= ST_LOAD;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         exp_b_q  <= 6'd0;
         exp_r_q  <= 8'sd0;
         man_a_q  <= 29'd0;
         man_b_q  <= 29'd0;
         sum_q    <= 30'd0;
         data_q   <= 32'd0;
         status_q <= 4'd0;
      end else begin
         state_q  <= state_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         exp_b_q  <= exp_b_d;
         exp_r_q  <= exp_r_d;
         man_a_q  <= man_a_d;
         man_b_q  <= man_b_d;
         sum_q    <= sum_d;
         data_q   <= data_d;
         status_q <= status_d;
      end
   end

   assign bus.data_out   = data_q;
   assign bus.status_out = status_q;
   assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_fpu_adder.sv
// Directed-vector bench for fpu_adder: drivers queue the hand-computed result,
// a monitor pops and compares it on the edge that leaves OUT.
module tb_fpu_adder;
   localparam logic [2:0] S_LOAD = 3'd0;
   localparam logic [2:0] S_OUT  = 3'd4;

   logic clk;
   logic rst;
   fpu_adder_if bus ();

   fpu_adder dut (.clock100KHz(clk), .reset(rst), .bus(bus));

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   logic [35:0] exp_q[$];
   logic out_seen = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Scoreboard monitor
   always @(posedge clk) out_seen <= (bus.dbg_state == S_OUT) && !rst;

   always @(negedge clk) begin
      if (out_seen && exp_q.size() != 0) begin
         logic [35:0] e;
         e = exp_q.pop_front();
         check("data_out", bus.data_out, e[31:0]);
         check("status_out", {28'd0, bus.status_out}, {28'd0, e[35:32]});
      end
   end

   // Drivers
   task automatic apply_and_queue(input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] d, input logic [3:0] s);
      bit seen;
      @(negedge clk);
      bus.op_A_in = a;
      bus.op_B_in = b;
      seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         if (bus.dbg_state == S_LOAD) seen = 1;
         else @(negedge clk);
      end
      if (!seen) check("load_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      exp_q.push_back({s, d});
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         check("result_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
   endtask

   task automatic run_vec(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] d, input logic [3:0] s);
      apply_and_queue(a, b, d, s);
      wait_drain();
   endtask

   initial begin
      rst = 1'b1;
      bus.op_A_in = 32'd0;
      bus.op_B_in = 32'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset_data", bus.data_out, 32'd0);
      check("reset_status", {28'd0, bus.status_out}, 32'd0);
      check("reset_state", {29'd0, bus.dbg_state}, {29'd0, S_LOAD});

      run_vec(32'h0, 32'h0, 32'h0, 4'b1000);
      run_vec({1'b0, 6'd31, 25'd0}, {1'b0, 6'd31, 25'd0}, {1'b0, 6'd32, 25'd0}, 4'b1000);
      run_vec({1'b0, 6'd31, 25'd0}, {1'b1, 6'd31, 25'd0}, 32'h0, 4'b1000);
      run_vec({1'b0, 6'd50, 25'd100}, {1'b0, 6'd10, 25'd100}, {1'b0, 6'd50, 25'd100}, 4'b0001);
      run_vec({1'b0, 6'd31, 25'h0FFFFFF}, {1'b0, 6'd31, 25'd1}, {1'b0, 6'd32, 25'h0800000}, 4'b1000);
      run_vec({1'b0, 6'd63, 25'h1FFFFFF}, {1'b0, 6'd63, 25'h1FFFFFF}, {1'b0, 6'd63, 25'h1FFFFFF}, 4'b0100);
      run_vec({1'b0, 6'd1, 25'd1}, {1'b1, 6'd1, 25'd0}, 32'h0, 4'b0010);
      run_vec({1'b1, 6'd32, 25'd0}, {1'b1, 6'd32, 25'd0}, {1'b1, 6'd33, 25'd0}, 4'b1000);
      run_vec({1'b0, 6'd33, 25'd0}, {1'b1, 6'd32, 25'd0}, {1'b0, 6'd32, 25'd0}, 4'b1000);
      // Zero operand in either position passes the other through unchanged
      run_vec({1'b1, 6'd40, 25'h12345}, 32'h0, {1'b1, 6'd40, 25'h12345}, 4'b1000);
      run_vec(32'h0, {1'b0, 6'd20, 25'h1ABCDE}, {1'b0, 6'd20, 25'h1ABCDE}, 4'b1000);
      // Exponent gap 20: B contributes 100>>... = 32 to the fraction, sticky set
      run_vec({1'b0, 6'd50, 25'd100}, {1'b0, 6'd30, 25'd100}, {1'b0, 6'd50, 25'd132}, 4'b0001);

      // Reset during ALIGN; the queued result must come from the following pass
      run_vec({1'b0, 6'd31, 25'd0}, {1'b0, 6'd31, 25'd0}, {1'b0, 6'd32, 25'd0}, 4'b1000);
      apply_and_queue({1'b0, 6'd50, 25'd100}, {1'b0, 6'd30, 25'd100}, {1'b0, 6'd50, 25'd132}, 4'b0001);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midreset_data", bus.data_out, 32'd0);
      check("midreset_status", {28'd0, bus.status_out}, 32'd0);
      check("midreset_state", {29'd0, bus.dbg_state}, {29'd0, S_LOAD});
      wait_drain();

      // Final report
      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
